// File: rtl/serial_cmd_pkg.sv
// Shared command/response codes and parser state encoding for serial_cmd_decoder.
package serial_cmd_pkg;

  // Command bytes accepted at the start of a frame
  localparam logic [7:0] CMD_READ   = 8'h01;
  localparam logic [7:0] CMD_WRITE  = 8'h02;

  // Response codes: OK = 0x80 | cmd, timeout = 0xC0 | cmd, unknown command = 0xFF
  localparam logic [7:0] RSP_OK_BIT = 8'h80;
  localparam logic [7:0] RSP_TO_BIT = 8'h40;
  localparam logic [7:0] RSP_BAD    = 8'hFF;

  // Parser state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_BUS     = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter: counts while enabled, flags expiry once LIMIT is reached.
module timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_reg;

  // Count up while enabled; hold at LIMIT so the counter never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT_V)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = (count_reg == LIMIT_V);

endmodule

// File: rtl/serial_cmd_decoder.sv
// Parses UART command frames into 16-bit bus reads/writes and returns a response frame.
module serial_cmd_decoder
  import serial_cmd_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 400000,
  parameter int BUS_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  as_data_i,
  input  logic        as_dstrb_i,
  output logic [7:0]  as_data_o,
  output logic        as_dstrb_o,
  input  logic        as_busy_i,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [15:0] bus_adr_o,
  output logic [15:0] bus_dat_o,
  input  logic [15:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        overrun
);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  cmd_reg;
  logic [15:0] adr_reg, dat_reg;
  logic        bus_cyc_reg, bus_we_reg;
  logic [7:0]  rsp_reg [0:2];
  logic [1:0]  rsp_cnt_reg, rsp_idx_reg;
  logic        dstrb_prev_reg, overrun_reg;

  logic byte_run, byte_expired, bus_expired, bus_done;
  logic cmd_ok, send, last_send;

  // Byte timer only runs while a frame is partially received
  assign byte_run  = (state_reg == ST_ADDR_HI) || (state_reg == ST_ADDR_LO) ||
                     (state_reg == ST_DATA_HI) || (state_reg == ST_DATA_LO);
  assign cmd_ok    = (as_data_i == CMD_READ) || (as_data_i == CMD_WRITE);
  // An ack in the expiry cycle still wins because bus_ack_i is tested first below
  assign bus_done  = bus_cyc_reg && (bus_ack_i || bus_expired);
  // Transmit only when UART is idle and we did not strobe on the previous cycle
  assign send      = (state_reg == ST_RESP) && !as_busy_i && !dstrb_prev_reg;
  assign last_send = send && (rsp_idx_reg == (rsp_cnt_reg - 2'd1));

  timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (as_dstrb_i || !byte_run),
    .enable  (byte_run),
    .expired (byte_expired)
  );

  // Counting starts on BUS entry, so expiry lands after exactly BUS_TIMEOUT cycles of bus_cyc_o
  timeout_counter #(.LIMIT(BUS_TIMEOUT)) u_bus_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg != ST_BUS),
    .enable  (state_reg == ST_BUS),
    .expired (bus_expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; a byte arriving with an expiring timer is still accepted
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (as_dstrb_i) state_next = cmd_ok ? ST_ADDR_HI : ST_RESP;
      ST_ADDR_HI: if (as_dstrb_i) state_next = ST_ADDR_LO;
                  else if (byte_expired) state_next = ST_IDLE;
      ST_ADDR_LO: if (as_dstrb_i) state_next = (cmd_reg == CMD_WRITE) ? ST_DATA_HI : ST_BUS;
                  else if (byte_expired) state_next = ST_IDLE;
      ST_DATA_HI: if (as_dstrb_i) state_next = ST_DATA_LO;
                  else if (byte_expired) state_next = ST_IDLE;
      ST_DATA_LO: if (as_dstrb_i) state_next = ST_BUS;
                  else if (byte_expired) state_next = ST_IDLE;
      ST_BUS:     if (bus_done) state_next = ST_RESP;
      ST_RESP:    if (last_send) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output logic: transmit strobe is combinational so it tracks as_busy_i in the same cycle
  always_comb begin
    as_dstrb_o = send;
    as_data_o  = rsp_reg[rsp_idx_reg];
  end

  assign bus_cyc_o = bus_cyc_reg;
  assign bus_we_o  = bus_we_reg;
  assign bus_adr_o = adr_reg;
  assign bus_dat_o = dat_reg;
  assign overrun   = overrun_reg;

  // Datapath: field capture, bus cycle control, response holding register, overrun flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_reg        <= '0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      bus_cyc_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      rsp_cnt_reg    <= 2'd1;
      rsp_idx_reg    <= '0;
      dstrb_prev_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      for (int i = 0; i < 3; i++) rsp_reg[i] <= '0;
    end else begin
      dstrb_prev_reg <= send;
      if (as_dstrb_i && ((state_reg == ST_BUS) || (state_reg == ST_RESP)))
        overrun_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: if (as_dstrb_i) begin
          cmd_reg     <= as_data_i;
          rsp_idx_reg <= '0;
          if (!cmd_ok) begin
            rsp_reg[0]  <= RSP_BAD;
            rsp_cnt_reg <= 2'd1;
          end
        end
        ST_ADDR_HI: if (as_dstrb_i) adr_reg[15:8] <= as_data_i;
        ST_ADDR_LO: if (as_dstrb_i) adr_reg[7:0]  <= as_data_i;
        ST_DATA_HI: if (as_dstrb_i) dat_reg[15:8] <= as_data_i;
        ST_DATA_LO: if (as_dstrb_i) dat_reg[7:0]  <= as_data_i;
        ST_BUS: begin
          if (!bus_cyc_reg) begin
            bus_cyc_reg <= 1'b1;
            bus_we_reg  <= (cmd_reg == CMD_WRITE);
          end else if (bus_done) begin
            bus_cyc_reg <= 1'b0;
            bus_we_reg  <= 1'b0;
            rsp_idx_reg <= '0;
            if (bus_ack_i) begin
              rsp_reg[0]  <= RSP_OK_BIT | cmd_reg;
              rsp_reg[1]  <= bus_dat_i[15:8];
              rsp_reg[2]  <= bus_dat_i[7:0];
              rsp_cnt_reg <= (cmd_reg == CMD_WRITE) ? 2'd1 : 2'd3;
            end else begin
              rsp_reg[0]  <= RSP_OK_BIT | RSP_TO_BIT | cmd_reg;
              rsp_cnt_reg <= 2'd1;
            end
          end
        end
        ST_RESP: if (send) rsp_idx_reg <= rsp_idx_reg + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_cmd_decoder.md
Name: serial_cmd_decoder

Overview:
Consumes the byte stream from the serial UART receive side and parses fixed-format command frames. Each valid frame becomes one 16-bit register read or write on the monitor's internal bus. The block then returns a response frame through the same UART's transmit side. It sits directly between the UART host interface and the bus master port.

Parameters:
BYTE_TIMEOUT, 400000, cycles allowed between consecutive bytes of one frame (10 ms at 40 MHz) before the partial frame is discarded
BUS_TIMEOUT, 1024, cycles to wait for bus_ack_i before aborting the bus cycle

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
as_data_i  in  8  received byte from UART, valid on as_dstrb_i
as_dstrb_i  in  1  one-cycle strobe, new received byte
as_data_o  out  8  byte to UART transmitter
as_dstrb_o  out  1  one-cycle transmit strobe
as_busy_i  in  1  UART transmitter busy
bus_cyc_o  out  1  bus cycle active
bus_we_o  out  1  1 = write, 0 = read
bus_adr_o  out  16  bus address
bus_dat_o  out  16  write data
bus_dat_i  in  16  read data, valid with bus_ack_i
bus_ack_i  in  1  bus acknowledge, one cycle
overrun  out  1  sticky: a byte was dropped while a frame was being processed

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset values:
  - as_dstrb_o=0, bus_cyc_o=0, bus_we_o=0, overrun=0
  - as_data_o, bus_adr_o, bus_dat_o = 0
  - state = IDLE
- Frame format (multi-byte fields MSB first):
  - Read: 0x01, ADDR_HI, ADDR_LO.
  - Write: 0x02, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO.
- Responses:
  - Read OK: 0x81, D_HI, D_LO.
  - Write OK: 0x82.
  - Read bus timeout: 0xC1.
  - Write bus timeout: 0xC2.
  - Any other command byte: 0xFF.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, BUS, RESP.
- IDLE, on as_dstrb_i:
  - Latch the command byte.
  - 0x01 or 0x02 -> ADDR_HI.
  - Anything else -> queue 0xFF, go to RESP.
- ADDR_HI and ADDR_LO capture the address bytes.
- After ADDR_LO: read goes to BUS; write goes to DATA_HI, then DATA_LO, then BUS.
- Byte timer:
  - Cleared on every accepted byte.
  - Runs in ADDR_HI through DATA_LO.
  - Reaching BYTE_TIMEOUT returns to IDLE silently; no response.
- BUS state:
  - bus_cyc_o is asserted on the cycle after entry.
  - bus_adr_o, bus_dat_o and bus_we_o are held stable for the whole cycle.
  - bus_ack_i is ignored when bus_cyc_o=0.
  - On bus_ack_i: capture bus_dat_i, deassert bus_cyc_o on the next edge, queue the OK response.
  - If BUS_TIMEOUT cycles elapse with no ack: deassert bus_cyc_o, queue the timeout response.
  - Ack arriving on the same cycle the timeout expires: treated as ack (success).
- RESP state:
  - Response bytes go into a 3-entry holding register with a count of 1 or 3.
  - A byte is sent by asserting as_dstrb_o for exactly one cycle, with as_data_o valid, only in a cycle where as_busy_i=0 and as_dstrb_o was 0 on the previous cycle.
  - After the last byte's strobe -> IDLE.
  - Response latency: first strobe no earlier than 1 cycle after bus completion.
- Byte drops:
  - Any as_dstrb_i while in BUS or RESP is dropped and sets overrun.
  - overrun clears only on reset.
- Reset asserted mid-operation:
  - bus_cyc_o and as_dstrb_o drop immediately (asynchronous).
  - Parser returns to IDLE; the partial response is lost.
- Timer widths: clog2(parameter+1); the counters saturate and never wrap.

Decomposition:
- Shared package serial_cmd_pkg holds:
  - command codes CMD_READ=8'h01, CMD_WRITE=8'h02
  - response codes RSP_OK_BIT=8'h80, RSP_TO_BIT=8'h40, RSP_BAD=8'hFF
  - the state encoding localparams
- One sub-module: timeout_counter (clear, enable, parameterised LIMIT, expired output), instantiated twice: byte timer and bus timer.

Test Plan:
- Read: send 01 12 34; bus acks after 5 cycles with 16'hBEEF -> bus_adr_o=16'h1234, bus_we_o=0; UART receives 81 BE EF.
- Write: send 02 00 10 A5 5A; ack after 1 cycle -> bus_we_o=1, bus_adr_o=16'h0010, bus_dat_o=16'hA55A; single response 82.
- Bus timeout: read 01 00 20, never ack -> bus_cyc_o high exactly BUS_TIMEOUT cycles then low; response C1 only.
- Bad command / byte timeout: byte 0x37 -> response FF. Separately, 02 00 then silence for BYTE_TIMEOUT+1 cycles -> no bus cycle and no response; then 01 00 00 is handled normally.
- Backpressure and overrun:
  - Hold as_busy_i=1 for 200 cycles during RESP of a read -> no strobe while busy; the three bytes are emitted in order afterwards.
  - Inject a byte during BUS -> overrun=1 and the frame result is unaffected.
- Reset mid-frame: assert reset during BUS with bus_cyc_o=1 -> bus_cyc_o=0 asynchronously, overrun=0, no response; the next valid frame succeeds.
